// File: rtl/pingpong_frame_buffer.sv
// rtl/pingpong_frame_buffer.sv - double-buffered pixel store with tear-free bank swap and clear engine
module pingpong_frame_buffer #(
  parameter int                    BUFFER_WIDTH  = 512,
  parameter int                    BUFFER_HEIGHT = 342,
  parameter int                    PIXEL_BITS    = 1,
  parameter int                    DEPTH         = BUFFER_WIDTH * BUFFER_HEIGHT,
  parameter int                    ADDR_WIDTH    = $clog2(DEPTH),
  parameter logic [PIXEL_BITS-1:0] CLEAR_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [PIXEL_BITS-1:0] write_data,
  input  logic                  write_frame_done,
  input  logic                  clear_req,
  input  logic                  read_frame_start,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [PIXEL_BITS-1:0] read_data,
  output logic                  read_valid,
  output logic                  front_bank,
  output logic                  frame_pending,
  output logic                  clear_busy,
  output logic [7:0]            drop_count
);

  // Index width of one bank; the address port may be wider so out-of-range addresses are expressible.
  localparam int                    IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic                    front_q;
  logic                    pending_q;
  logic                    busy_q;
  logic [7:0]              drop_q;
  logic [7:0]              drop_d;
  logic [PIXEL_BITS-1:0]   rd_data_q;
  logic [PIXEL_BITS-1:0]   rd_data_d;
  logic                    rd_valid_q;

  // Both banks: bank select is the outer index, pixel index the inner one.
  logic [PIXEL_BITS-1:0]   mem [2][DEPTH];

  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    swap;
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [PIXEL_BITS-1:0]   mem_wdata;

  assign wr_in_range = ({1'b0, write_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, read_addr} < DEPTH_W);
  // pending_q is never set while clearing, so a swap can only happen from IDLE.
  assign swap        = read_frame_start && pending_q;
  assign drop_d      = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  // Back-bank write port: clear engine has priority, user writes only while idle and not pending.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_addr[IDX_W-1:0];
    mem_wdata = write_data;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q[IDX_W-1:0];
      mem_wdata = CLEAR_VALUE;
    end else if (write_enable && wr_in_range && !pending_q) begin
      mem_we = 1'b1;
    end
  end

  // Pixel storage is not reset; writes always land in the bank not being scanned out.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[~front_q][mem_waddr] <= mem_wdata;
    end
  end

  // Front-bank lookup; out-of-range addresses read as zero.
  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) begin
      rd_data_d = mem[front_q][read_addr[IDX_W-1:0]];
    end
  end

  // Registered read: data holds when idle, valid follows the strobe by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= read_enable;
      if (read_enable) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  // Control FSM: frame handshake, bank swap, drop counting and the clear engine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (swap) begin
            front_q <= ~front_q;
          end
          if (clear_req) begin
            state_q    <= ST_CLEAR;
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
            pending_q  <= 1'b0;
          end else if (swap) begin
            // A frame completing on the swap edge marks the freshly exposed back bank.
            pending_q <= write_frame_done;
          end else if (write_frame_done) begin
            if (pending_q) begin
              drop_q <= drop_d;
            end else begin
              pending_q <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (write_frame_done) begin
            drop_q <= drop_d;
          end
          if (clr_addr_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          clr_addr_q <= clr_addr_q + ADDR_ONE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign read_data     = rd_data_q;
  assign read_valid    = rd_valid_q;
  assign front_bank    = front_q;
  assign frame_pending = pending_q;
  assign clear_busy    = busy_q;
  assign drop_count    = drop_q;

endmodule
